// File: rtl/mbc_quad_loader_if.sv
// Signal bundle between the MB quadword loader and its requester, memory and MB datapath.
// The requester pulses mbc_rd_rq_h for one cycle and needs no ready: the pulse is taken only while mbc_busy_h=0.
interface mbc_quad_loader_if;
    logic       mbc_rd_rq_h;
    logic [1:0] mbc_first_adr_h;
    logic       mem_data_valid_h;
    logic       nxm_any_l;
    logic       mb_in_sel_1_h;
    logic       mb_in_sel_2_h;
    logic       mb_in_sel_4_h;
    logic       mb0_hold_in_h;
    logic       mb1_hold_in_h;
    logic       mb2_hold_in_h;
    logic       mb3_hold_in_h;
    logic       mb_sel_1_en_h;
    logic       mb_sel_2_en_h;
    logic       mb_sel_hold_h;
    logic       mbc_busy_h;
    logic       mbc_done_h;
    logic       mbc_nxm_err_h;

    modport master (
        output mbc_rd_rq_h, mbc_first_adr_h, mem_data_valid_h, nxm_any_l,
        input  mb_in_sel_1_h, mb_in_sel_2_h, mb_in_sel_4_h,
        input  mb0_hold_in_h, mb1_hold_in_h, mb2_hold_in_h, mb3_hold_in_h,
        input  mb_sel_1_en_h, mb_sel_2_en_h, mb_sel_hold_h,
        input  mbc_busy_h, mbc_done_h, mbc_nxm_err_h
    );

    modport slave (
        input  mbc_rd_rq_h, mbc_first_adr_h, mem_data_valid_h, nxm_any_l,
        output mb_in_sel_1_h, mb_in_sel_2_h, mb_in_sel_4_h,
        output mb0_hold_in_h, mb1_hold_in_h, mb2_hold_in_h, mb3_hold_in_h,
        output mb_sel_1_en_h, mb_sel_2_en_h, mb_sel_hold_h,
        output mbc_busy_h, mbc_done_h, mbc_nxm_err_h
    );
endinterface

// File: rtl/mbc_quad_loader.sv
// Quadword memory-to-MB loader: steers four memory words into MB starting at a wrapping word pointer.
// Every output is a flop; output flops are loaded from the decode of the next state.
module mbc_quad_loader (
    input  logic                    clk_mb_00_h,
    input  logic                    mr_reset_l,
    mbc_quad_loader_if.slave        bus,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e     st_q, st_d;
    logic [1:0] wp_q, wp_d;
    logic [1:0] adr_q, adr_d;
    logic [2:0] wc_q, wc_d;
    logic [3:0] tc_q, tc_d;
    logic       err_q, err_d;

    logic [2:0] sel_q, sel_d;
    logic [3:0] hold_q, hold_d;
    logic       sel_hold_q, sel_hold_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk_mb_00_h) begin
        if (!mr_reset_l) begin
            st_q       <= S_IDLE;
            wp_q       <= 2'd0;
            adr_q      <= 2'd0;
            wc_q       <= 3'd0;
            tc_q       <= 4'd0;
            err_q      <= 1'b0;
            sel_q      <= 3'd0;
            hold_q     <= 4'd0;
            sel_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            wp_q       <= wp_d;
            adr_q      <= adr_d;
            wc_q       <= wc_d;
            tc_q       <= tc_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            sel_hold_q <= sel_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        wp_d  = wp_q;
        adr_d = adr_q;
        wc_d  = wc_q;
        tc_d  = tc_q;
        err_d = err_q;
        case (st_q)
            S_IDLE: begin
                if (bus.mbc_rd_rq_h) begin
                    st_d  = S_WAIT;
                    wp_d  = bus.mbc_first_adr_h;
                    adr_d = bus.mbc_first_adr_h;
                    wc_d  = 3'd0;
                    tc_d  = 4'd0;
                    err_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!bus.nxm_any_l) begin
                    st_d  = S_DONE;
                    err_d = 1'b1;
                end else if (bus.mem_data_valid_h) begin
                    st_d = S_LOAD;
                end else if (tc_q == 4'd15) begin
                    st_d  = S_DONE;
                    err_d = 1'b1;
                end else begin
                    tc_d = tc_q + 4'd1;
                end
            end
            S_LOAD: begin
                // The strobe for wp_q is already out; NXM only redirects where we go next.
                wp_d = wp_q + 2'd1;
                wc_d = wc_q + 3'd1;
                tc_d = 4'd0;
                if (!bus.nxm_any_l) begin
                    st_d  = S_DONE;
                    err_d = 1'b1;
                end else if (wc_q == 3'd3) begin
                    st_d = S_DONE;
                end else begin
                    st_d = S_WAIT;
                end
            end
            S_DONE: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_d        = 3'd0;
        hold_d       = 4'd0;
        sel_hold_d   = 1'b0;
        busy_d       = (st_d != S_IDLE);
        done_d       = (st_d == S_DONE);
        if (st_d == S_LOAD) begin
            sel_d        = 3'b100;
            hold_d[wp_d] = 1'b1;
        end
        if (st_d == S_IDLE || st_d == S_DONE) begin
            sel_hold_d = 1'b1;
        end
    end

    assign bus.mb_in_sel_1_h = sel_q[0];
    assign bus.mb_in_sel_2_h = sel_q[1];
    assign bus.mb_in_sel_4_h = sel_q[2];
    assign bus.mb0_hold_in_h = hold_q[0];
    assign bus.mb1_hold_in_h = hold_q[1];
    assign bus.mb2_hold_in_h = hold_q[2];
    assign bus.mb3_hold_in_h = hold_q[3];
    assign bus.mb_sel_1_en_h = adr_q[0];
    assign bus.mb_sel_2_en_h = adr_q[1];
    assign bus.mb_sel_hold_h = sel_hold_q;
    assign bus.mbc_busy_h    = busy_q;
    assign bus.mbc_done_h    = done_q;
    assign bus.mbc_nxm_err_h = err_q;
    assign dbg_state_o       = st_q;

endmodule

// File: tb/tb_mbc_quad_loader.sv
// Directed bench for mbc_quad_loader: expected strobe/done events are queued at stimulus time
// and a negedge monitor pops and compares each event the loader presents.
module tb_mbc_quad_loader;

    localparam int W = 13;
    // Observation word: {done, nxm_err, busy, sel_hold, sel4, sel2, sel1, hold[3:0], sel_en[1:0]}
    localparam logic [W-1:0] RST_OBS = 13'b0_0_0_1_000_0000_00;

    logic       clk_mb_00_h;
    logic       mr_reset_l;
    logic [1:0] dbg_state;

    mbc_quad_loader_if bus ();

    mbc_quad_loader dut (
        .clk_mb_00_h (clk_mb_00_h),
        .mr_reset_l  (mr_reset_l),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk_mb_00_h = 1'b0;
    always #5 clk_mb_00_h = ~clk_mb_00_h;

    int cyc = 0;
    always @(posedge clk_mb_00_h) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog sim_time_exceeded got=running want=finished");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] obs;
    assign obs = {bus.mbc_done_h, bus.mbc_nxm_err_h, bus.mbc_busy_h, bus.mb_sel_hold_h,
                  bus.mb_in_sel_4_h, bus.mb_in_sel_2_h, bus.mb_in_sel_1_h,
                  bus.mb3_hold_in_h, bus.mb2_hold_in_h, bus.mb1_hold_in_h, bus.mb0_hold_in_h,
                  bus.mb_sel_2_en_h, bus.mb_sel_1_en_h};

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cyc = -1;

    function automatic logic [W-1:0] ev_strobe(input logic [1:0] w, input logic [1:0] adr);
        logic [3:0] h;
        h = 4'b0000;
        h[w] = 1'b1;
        return {1'b0, 1'b0, 1'b1, 1'b0, 3'b100, h, adr};
    endfunction

    function automatic logic [W-1:0] ev_done(input logic err, input logic [1:0] adr);
        return {1'b1, err, 1'b1, 1'b1, 3'b000, 4'b0000, adr};
    endfunction

    function automatic logic [W-1:0] idle_obs(input logic err, input logic [1:0] adr);
        return {1'b0, err, 1'b0, 1'b1, 3'b000, 4'b0000, adr};
    endfunction

    always @(negedge clk_mb_00_h) begin
        logic [W-1:0] e;
        if (mr_reset_l && ((|obs[5:2]) || obs[12])) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d got=%b want=%b", cyc, obs, e);
                end
            end
            if (|obs[5:2]) strobe_cnt++;
            if (obs[12]) done_cyc = cyc;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk_mb_00_h);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.mbc_busy_h && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (bus.mbc_busy_h) begin
            errors++;
            $display("FAIL %s_timeout busy got=1 want=0", name);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic request(input logic [1:0] adr);
        bus.mbc_rd_rq_h     = 1'b1;
        bus.mbc_first_adr_h = adr;
        step();
        bus.mbc_rd_rq_h     = 1'b0;
    endtask

    int t0;

    initial begin
        mr_reset_l           = 1'b0;
        bus.mbc_rd_rq_h      = 1'b0;
        bus.mbc_first_adr_h  = 2'd0;
        bus.mem_data_valid_h = 1'b0;
        bus.nxm_any_l        = 1'b1;
        repeat (3) step();
        check("reset_outputs", obs, RST_OBS);
        check_int("reset_state", int'(dbg_state), 0);
        mr_reset_l = 1'b1;
        step();

        // Spaced valids, first word 2: order 2,3,0,1
        strobe_cnt = 0;
        exp_q.push_back(ev_strobe(2'd2, 2'd2));
        exp_q.push_back(ev_strobe(2'd3, 2'd2));
        exp_q.push_back(ev_strobe(2'd0, 2'd2));
        exp_q.push_back(ev_strobe(2'd1, 2'd2));
        exp_q.push_back(ev_done(1'b0, 2'd2));
        request(2'd2);
        repeat (4) begin
            step();
            step();
            bus.mem_data_valid_h = 1'b1;
            step();
            bus.mem_data_valid_h = 1'b0;
            step();
        end
        wait_idle("spaced");
        check_drained("spaced");
        check("spaced_idle", obs, idle_obs(1'b0, 2'd2));

        // Valid held high: W/L alternate, 4 strobes in 8 cycles, done on the 9th
        strobe_cnt = 0;
        exp_q.push_back(ev_strobe(2'd1, 2'd1));
        exp_q.push_back(ev_strobe(2'd2, 2'd1));
        exp_q.push_back(ev_strobe(2'd3, 2'd1));
        exp_q.push_back(ev_strobe(2'd0, 2'd1));
        exp_q.push_back(ev_done(1'b0, 2'd1));
        bus.mem_data_valid_h = 1'b1;
        request(2'd1);
        t0 = cyc;
        wait_idle("burst");
        bus.mem_data_valid_h = 1'b0;
        check_drained("burst");
        check_int("burst_strobes", strobe_cnt, 4);
        check_int("burst_done_cycle", done_cyc - t0, 8);

        // No valid: timeout after 16 WAIT cycles, sticky error
        strobe_cnt = 0;
        exp_q.push_back(ev_done(1'b1, 2'd3));
        request(2'd3);
        t0 = cyc;
        wait_idle("timeout");
        check_drained("timeout");
        check_int("timeout_strobes", strobe_cnt, 0);
        check_int("timeout_done_cycle", done_cyc - t0, 16);
        step();
        check("timeout_err_sticky", obs, idle_obs(1'b1, 2'd3));

        // NXM during second LOAD: that strobe completes, then done with error
        strobe_cnt = 0;
        exp_q.push_back(ev_strobe(2'd0, 2'd0));
        exp_q.push_back(ev_strobe(2'd1, 2'd0));
        exp_q.push_back(ev_done(1'b1, 2'd0));
        request(2'd0);
        bus.mem_data_valid_h = 1'b1;
        step();
        bus.mem_data_valid_h = 1'b0;
        step();
        bus.mem_data_valid_h = 1'b1;
        step();
        bus.nxm_any_l = 1'b0;
        step();
        bus.nxm_any_l = 1'b1;
        bus.mem_data_valid_h = 1'b0;
        wait_idle("nxm");
        check_drained("nxm");
        check_int("nxm_strobes", strobe_cnt, 2);
        check("nxm_idle", obs, idle_obs(1'b1, 2'd0));

        // Requests while busy (in WAIT, LOAD and DONE) are dropped
        strobe_cnt = 0;
        exp_q.push_back(ev_strobe(2'd2, 2'd2));
        exp_q.push_back(ev_strobe(2'd3, 2'd2));
        exp_q.push_back(ev_strobe(2'd0, 2'd2));
        exp_q.push_back(ev_strobe(2'd1, 2'd2));
        exp_q.push_back(ev_done(1'b0, 2'd2));
        bus.mem_data_valid_h = 1'b1;
        request(2'd2);
        t0 = cyc;
        step();
        step();
        bus.mbc_rd_rq_h     = 1'b1;
        bus.mbc_first_adr_h = 2'd0;
        step();
        step();
        bus.mbc_rd_rq_h = 1'b0;
        while (cyc < t0 + 8) step();
        bus.mbc_rd_rq_h = 1'b1;
        step();
        bus.mbc_rd_rq_h = 1'b0;
        bus.mem_data_valid_h = 1'b0;
        repeat (5) step();
        check_drained("busy_rq");
        check_int("busy_rq_strobes", strobe_cnt, 4);
        check("busy_rq_idle", obs, idle_obs(1'b0, 2'd2));

        // Reset after two strobes, then a fresh transfer from its own address
        strobe_cnt = 0;
        exp_q.push_back(ev_strobe(2'd1, 2'd1));
        exp_q.push_back(ev_strobe(2'd2, 2'd1));
        bus.mem_data_valid_h = 1'b1;
        request(2'd1);
        for (int n = 0; n < 30 && strobe_cnt < 2; n++) begin
            @(negedge clk_mb_00_h);
            #1;
        end
        check_int("abort_strobes_before_reset", strobe_cnt, 2);
        mr_reset_l = 1'b0;
        step();
        check("abort_reset_outputs", obs, RST_OBS);
        check_int("abort_reset_state", int'(dbg_state), 0);
        mr_reset_l = 1'b1;
        bus.mem_data_valid_h = 1'b0;
        step();
        check("abort_after_reset", obs, RST_OBS);
        check_drained("abort");
        strobe_cnt = 0;
        exp_q.push_back(ev_strobe(2'd3, 2'd3));
        exp_q.push_back(ev_strobe(2'd0, 2'd3));
        exp_q.push_back(ev_strobe(2'd1, 2'd3));
        exp_q.push_back(ev_strobe(2'd2, 2'd3));
        exp_q.push_back(ev_done(1'b0, 2'd3));
        bus.mem_data_valid_h = 1'b1;
        request(2'd3);
        wait_idle("restart");
        bus.mem_data_valid_h = 1'b0;
        step();
        check_drained("restart");
        check_int("restart_strobes", strobe_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
